// File: rtl/program_loader.sv
// Framed byte-stream loader for the 16-entry instruction memory; holds the CPU in reset until a checksum-verified load.
// Optional post-load HALT fill of unloaded locations: define PROGRAM_LOADER_FILL_EN.
module program_loader #(
  parameter int         ADDR_W         = 4,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1023
`ifdef PROGRAM_LOADER_FILL_EN
  , parameter logic [7:0] FILL_WORD    = 8'h70
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_error,
  output logic [1:0]        err_code,
  output logic [2:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
`ifdef PROGRAM_LOADER_FILL_EN
    , S_FILL = 3'd6
`endif
  } state_t;

  // Handshake: a byte moves on any posedge where in_valid && in_ready; in_ready depends on state only.
  state_t              r_state, w_state;
  logic [ADDR_W:0]     r_len, w_len, r_cnt, w_cnt;
  logic [7:0]          r_xor, w_xor;
  logic [TW-1:0]       r_tmo, w_tmo;
  logic                r_we, w_we;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [7:0]          r_wdata, w_wdata;
  logic                r_err, w_err;
  logic [1:0]          r_code, w_code;
  logic                w_xfer, w_sync, w_tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_xor   <= '0;
      r_tmo   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_code  <= 2'b00;
    end else begin
      r_state <= w_state;
      r_len   <= w_len;
      r_cnt   <= w_cnt;
      r_xor   <= w_xor;
      r_tmo   <= w_tmo;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_err   <= w_err;
      r_code  <= w_code;
    end
  end

  assign w_xfer    = in_valid && in_ready;
  assign w_sync    = w_xfer && (in_data == SYNC_BYTE);
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state = r_state;
    w_len   = r_len;
    w_cnt   = r_cnt;
    w_xor   = r_xor;
    w_tmo   = r_tmo;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_err   = r_err;
    w_code  = r_code;
    case (r_state)
      S_IDLE, S_ERROR: begin
        if ((r_state == S_ERROR) && reload) begin
          w_state = S_IDLE;
        end else if (w_sync) begin
          w_state = S_LEN;
          w_xor   = '0;
          w_cnt   = '0;
          w_tmo   = '0;
          w_err   = 1'b0;
          w_code  = 2'b00;
        end
      end
      S_LEN, S_DATA, S_CHK: begin
        if (w_xfer) begin
          w_tmo = '0;
          if (r_state == S_LEN) begin
            if ((in_data == 8'd0) || ({1'b0, in_data} > 9'(DEPTH))) begin
              w_state = S_ERROR;
              w_err   = 1'b1;
              w_code  = 2'b01;
            end else begin
              w_len   = in_data[ADDR_W:0];
              w_xor   = in_data;
              w_state = S_DATA;
            end
          end else if (r_state == S_DATA) begin
            w_we    = 1'b1;
            w_addr  = r_cnt[ADDR_W-1:0];
            w_wdata = in_data;
            w_xor   = r_xor ^ in_data;
            w_cnt   = r_cnt + 1'b1;
            if (r_cnt == r_len - 1'b1) w_state = S_CHK;
          end else if (in_data == r_xor) begin
            w_state = S_DONE;
`ifdef PROGRAM_LOADER_FILL_EN
            // First fill write is issued here so mem_we stays high for the whole FILL stay.
            if (r_len < (ADDR_W+1)'(DEPTH)) begin
              w_state = S_FILL;
              w_we    = 1'b1;
              w_addr  = r_len[ADDR_W-1:0];
              w_wdata = FILL_WORD;
              w_cnt   = r_len + 1'b1;
            end
`endif
          end else begin
            w_state = S_ERROR;
            w_err   = 1'b1;
            w_code  = 2'b10;
          end
        end else if (w_tmo_hit) begin
          w_state = S_ERROR;
          w_err   = 1'b1;
          w_code  = 2'b11;
        end else begin
          w_tmo = r_tmo + 1'b1;
        end
      end
`ifdef PROGRAM_LOADER_FILL_EN
      S_FILL: begin
        if (r_cnt == (ADDR_W+1)'(DEPTH)) begin
          w_state = S_DONE;
        end else begin
          w_we    = 1'b1;
          w_addr  = r_cnt[ADDR_W-1:0];
          w_wdata = FILL_WORD;
          w_cnt   = r_cnt + 1'b1;
        end
      end
`endif
      S_DONE: begin
        if (reload) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign in_ready     = (r_state == S_IDLE) || (r_state == S_LEN) || (r_state == S_DATA) ||
                        (r_state == S_CHK)  || (r_state == S_ERROR);
  assign busy         = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK)
`ifdef PROGRAM_LOADER_FILL_EN
                        || (r_state == S_FILL)
`endif
                        ;
  assign load_done    = (r_state == S_DONE);
  assign cpu_rst_hold = (r_state != S_DONE);
  assign load_error   = r_err;
  assign err_code     = r_code;
  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: write scoreboard plus status checks after each step.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       reload;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rst_hold, busy, load_done, load_error;
  logic [1:0] err_code;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b1;
  logic [11:0] exp_q[$];

  program_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_hold(cpu_rst_hold), .busy(busy), .load_done(load_done),
    .load_error(load_error), .err_code(err_code), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // {cpu_rst_hold, busy, load_done, load_error, err_code}
  task automatic check_stat(input string tag, input logic [5:0] exp);
    logic [5:0] s;
    s = {cpu_rst_hold, busy, load_done, load_error, err_code};
    check(tag, {26'd0, s}, {26'd0, exp});
  endtask

  task automatic check_reset_vals(input string tag);
    logic [22:0] v, e;
    v = {mem_we, mem_addr, mem_wdata, cpu_rst_hold, busy, load_done, load_error, err_code,
         in_ready, dbg_state};
    e = {1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd0};
    check(tag, {9'd0, v}, {9'd0, e});
  endtask

  // Transfers one byte; we/a/d give the write expected one cycle after acceptance.
  task automatic send_byte(input logic [7:0] b, input bit we, input logic [3:0] a,
                           input logic [7:0] d, input string tag);
    int n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    if (we && mon_en) exp_q.push_back({a, d});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_we"}, {31'd0, mem_we}, {31'd0, we});
  endtask

  task automatic send_pay(input logic [7:0] b, input logic [3:0] a);
    send_byte(b, 1'b1, a, b, "pay");
  endtask

  task automatic send_ctl(input logic [7:0] b);
    send_byte(b, 1'b0, 4'h0, 8'h00, "ctl");
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("write", {20'd0, mem_addr, mem_wdata}, {20'd0, e});
      end
    end
  end

  initial begin
    logic [7:0] x, b;
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; reload = 1'b0;
    #1;
    check_reset_vals("reset_vals");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic 3-byte load
    send_ctl(8'hA5);
    check_stat("after_sync", 6'b1_1_0_0_00);
    send_ctl(8'h03);
    send_pay(8'h05, 4'd0);
    send_pay(8'h21, 4'd1);
    send_pay(8'h70, 4'd2);
    send_ctl(8'h57);
    check_stat("load1_done", 6'b0_0_1_0_00);
    check("done_not_ready", {31'd0, in_ready}, 32'd0);

    // Leading junk is discarded
    pulse_reload();
    check_stat("reload_idle", 6'b1_0_0_0_00);
    send_ctl(8'h00);
    send_ctl(8'hFF);
    send_ctl(8'h3C);
    send_ctl(8'hA5);
    send_ctl(8'h01);
    send_pay(8'h60, 4'd0);
    send_ctl(8'h61);
    check_stat("load2_done", 6'b0_0_1_0_00);

    // Bad checksum, then recovery straight from ERROR
    pulse_reload();
    send_ctl(8'hA5);
    send_ctl(8'h03);
    send_pay(8'h05, 4'd0);
    send_pay(8'h21, 4'd1);
    send_pay(8'h70, 4'd2);
    send_ctl(8'h58);
    check_stat("chk_err", 6'b1_0_0_1_10);
    send_ctl(8'hA5);
    check_stat("sync_clears_err", 6'b1_1_0_0_00);
    send_ctl(8'h01);
    send_pay(8'h60, 4'd0);
    send_ctl(8'h61);
    check_stat("recover_done", 6'b0_0_1_0_00);

    // Bad lengths 0 and 17
    pulse_reload();
    send_ctl(8'hA5);
    send_ctl(8'h00);
    check_stat("len0_err", 6'b1_0_0_1_01);
    pulse_reload();
    check_stat("reload_keeps_err", 6'b1_0_0_1_01);
    check("reload_state_idle", {29'd0, dbg_state}, 32'd0);
    send_ctl(8'hA5);
    send_ctl(8'h11);
    check_stat("len17_err", 6'b1_0_0_1_01);

    // Maximum length 16
    send_ctl(8'hA5);
    send_ctl(8'h10);
    x = 8'h10;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      x = x ^ b;
      send_pay(b, 4'(i));
    end
    send_ctl(x);
    check_stat("len16_done", 6'b0_0_1_0_00);

    // Timeout at exactly TIMEOUT_CYCLES idle cycles
    pulse_reload();
    send_ctl(8'hA5);
    send_ctl(8'h04);
    send_pay(8'h10, 4'd0);
    send_pay(8'h20, 4'd1);
    repeat (1022) @(posedge clk);
    #1;
    check_stat("tmo_1022_busy", 6'b1_1_0_0_00);
    @(posedge clk);
    #1;
    check_stat("tmo_1023_err", 6'b1_0_0_1_11);

    // One cycle short of timeout, then a byte
    send_ctl(8'hA5);
    send_ctl(8'h04);
    send_pay(8'h10, 4'd0);
    send_pay(8'h20, 4'd1);
    repeat (1021) @(posedge clk);
    send_pay(8'h30, 4'd2);
    check_stat("tmo_short_ok", 6'b1_1_0_0_00);
    send_pay(8'h40, 4'd3);
    send_ctl(8'h44);
    check_stat("tmo_short_done", 6'b0_0_1_0_00);

`ifdef PROGRAM_LOADER_FILL_EN
    pulse_reload();
    send_ctl(8'hA5);
    send_ctl(8'h01);
    send_pay(8'h60, 4'd0);
    send_byte(8'h61, 1'b1, 4'd1, 8'h70, "fill_first");
    for (int a = 2; a < 16; a++) exp_q.push_back({4'(a), 8'h70});
    check("fill_not_ready", {31'd0, in_ready}, 32'd0);
    repeat (14) @(posedge clk);
    #1;
    check_stat("fill_busy", 6'b1_1_0_0_00);
    @(posedge clk);
    #1;
    check_stat("fill_done", 6'b0_0_1_0_00);

    pulse_reload();
    mon_en = 1'b0;
    send_ctl(8'hA5);
    send_ctl(8'h01);
    send_byte(8'h60, 1'b1, 4'd0, 8'h60, "fill_rst_pay");
    send_byte(8'h61, 1'b1, 4'd1, 8'h70, "fill_rst_chk");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid_fill");
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
`endif

    // Asynchronous reset mid-DATA drops the pending write
    pulse_reload();
    mon_en = 1'b0;
    send_ctl(8'hA5);
    send_ctl(8'h03);
    send_byte(8'h05, 1'b1, 4'd0, 8'h05, "rst_pay");
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid_data");
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    send_ctl(8'hA5);
    send_ctl(8'h01);
    send_pay(8'h60, 4'd0);
    send_ctl(8'h61);
    check_stat("post_rst_done", 6'b0_0_1_0_00);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
